seq_serializer: RTL and testbench
=================================

Name: seq_serializer

Overview:
- Upstream feeder for the serial 1001 sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clk, on a serial bit stream.
- Holds one word in a buffer so back-to-back words stream with no gap.
- seq_out connects directly to the detector's seq input.

Parameters:
- DATA_W, 8: word width in bits; legal range is 2 or more.
- IDLE_BIT, 1'b0: value driven on seq_out when no frame is active.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  parallel word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word; equals !hold_full.
- seq_out  out  1  serial bit, registered.
- seq_vld  out  1  seq_out carries a frame bit.
- word_done  out  1  one-cycle pulse while the last bit of a frame is on seq_out.
- busy  out  1  shifter active or hold buffer full.

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock. While rst_n is low and after release:
  - seq_out = IDLE_BIT, seq_vld = 0, word_done = 0, busy = 0.
  - hold_full = 0, so in_ready = 1.
  - State = IDLE, bit counter = 0.
- Handshake:
  - A transfer occurs on a rising edge with in_valid && in_ready.
  - in_ready depends only on registered state and never combinationally on in_valid.
  - in_data is ignored when no transfer occurs.
- States:
  - IDLE: shifter empty.
  - SHIFT: frame in progress. Counter runs FRAME_LEN-1 down to 0. FRAME_LEN = DATA_W, or DATA_W+1 with parity enabled.
- shifter_free = (state == IDLE) || (state == SHIFT && cnt == 0).
- Load priority at each edge where shifter_free is true:
  1. hold_full: load the shifter from hold and clear hold_full. A transfer in the same edge writes the hold buffer, so hold_full stays 1.
  2. Else a transfer: bypass. Load the shifter directly from in_data; hold stays empty.
  3. Else: go to IDLE. seq_out returns to IDLE_BIT and seq_vld to 0.
- Transfer while !shifter_free: the word goes into hold and hold_full is set.
- Latency: a word accepted at edge T with the shifter free has its MSB on seq_out during the cycle after T. Subsequent bits follow on consecutive cycles.
- Throughput: with in_valid held high, frames are gapless and seq_vld stays high continuously.
- Frame bit order: bit DATA_W-1 first, bit 0 last. seq_vld = 1 for exactly FRAME_LEN cycles per word.
- word_done is asserted while cnt == 0 in SHIFT.
- busy = (state == SHIFT) || hold_full.
- Counter width: CNT_W = $clog2(DATA_W+1). The counter never wraps; it is reloaded at frame start.
- Reset mid-frame: the partial frame and any held word are discarded, with no word_done. The first transfer after release behaves as from IDLE.

Optional Feature:
- Macro: SEQ_SERIALIZER_PARITY_EN.
- Defined:
  - Each frame is followed by one even-parity bit, the XOR of all DATA_W data bits, captured at shifter load.
  - FRAME_LEN = DATA_W + 1; word_done accompanies the parity bit.
- Undefined:
  - FRAME_LEN = DATA_W with no parity logic. Port list is unchanged.

Decomposition:
- Package seq_pkg:
  - state typedef (ST_IDLE, ST_SHIFT).
  - Helper constant function for CNT_W.
  - FRAME_LEN derivation under the macro.
- Sub-module seq_ser_hold: one-entry word buffer (data and full flag; write and take ports) used as the hold stage. The FSM, shifter and counter stay in the top level.

Test Plan:
- Reset, then one word 8'h90 with in_valid for a single cycle -> next cycle seq_out sequence 1,0,0,1,0,0,0,0; seq_vld high for 8 cycles; word_done on the 8th; a detector downstream reports 1001 once.
- Back-to-back 8'hA5, 8'h3C, 8'hFF with in_valid held -> 24 consecutive seq_vld cycles with no gap; in_ready low while hold is full; word_done at cycles 8, 16, 24.
- Transfer on the exact word_done cycle with hold empty -> bypass load; next frame's MSB appears on the following cycle and hold_full stays 0.
- in_valid held while the shifter is busy and hold is full -> in_ready = 0 and no transfer; data accepted only once hold is taken.
- rst_n pulsed low mid-frame at bit 3 of 8'h81 -> seq_out = IDLE_BIT and seq_vld = 0 immediately (asynchronous); no word_done; a new word 8'h09 afterwards emits 0,0,0,0,1,0,0,1.
- With SEQ_SERIALIZER_PARITY_EN, word 8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1 (parity 1); word_done on the 9th bit.

Source files
------------

// File: rtl/seq_serializer_pkg.sv
// Shared types and size helpers for the serial word feeder.
// Macro SEQ_SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
package seq_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic int clog2_f(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Counter must hold FRAME_LEN-1, which is at most DATA_W.
   function automatic int cnt_w_f(input int data_w);
      return clog2_f(data_w + 1);
   endfunction

`ifdef SEQ_SERIALIZER_PARITY_EN
   function automatic int frame_len_f(input int data_w);
      return data_w + 1;
   endfunction
`else
   function automatic int frame_len_f(input int data_w);
      return data_w;
   endfunction
`endif

endpackage

// File: rtl/seq_ser_hold.sv
// One-entry word buffer; a write in the same cycle as a take keeps it full.
module seq_ser_hold #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              take,
   output logic              full,
   output logic [DATA_W-1:0] data
);

   logic              full_reg;
   logic [DATA_W-1:0] data_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_reg <= 1'b0;
         data_reg <= '0;
      end else begin
         if (wr_en) begin
            full_reg <= 1'b1;
            data_reg <= wr_data;
         end else if (take) begin
            full_reg <= 1'b0;
         end
      end
   end

   assign full = full_reg;
   assign data = data_reg;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder, MSB first, with a one-word hold stage for gapless streaming.
// Optional even-parity trailer bit when SEQ_SERIALIZER_PARITY_EN is defined.
module seq_serializer
   import seq_pkg::*;
#(
   parameter int   DATA_W   = 8,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              seq_out,
   output logic              seq_vld,
   output logic              word_done,
   output logic              busy
);

   localparam int FRAME_LEN = frame_len_f(DATA_W);
   localparam int CNT_W     = cnt_w_f(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [DATA_W-1:0] sh_reg, sh_next;
   logic              seq_out_reg, seq_out_next;
`ifdef SEQ_SERIALIZER_PARITY_EN
   logic              par_reg, par_next;
`endif

   logic              hold_full;
   logic [DATA_W-1:0] hold_data;
   logic              hold_write;
   logic              hold_take;
   logic              xfer;
   logic              shifter_free;
   logic              load_en;
   logic [DATA_W-1:0] load_word;

   assign xfer         = in_valid && !hold_full;
   assign shifter_free = (state_reg == ST_IDLE) || (cnt_reg == '0);
   assign load_en      = shifter_free && (hold_full || xfer);
   assign load_word    = hold_full ? hold_data : in_data;
   assign hold_take    = shifter_free && hold_full;
   // A transfer only lands in hold when it cannot bypass straight into the shifter.
   assign hold_write   = xfer && !shifter_free;

   seq_ser_hold #(
      .DATA_W(DATA_W)
   ) u_hold (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (hold_write),
      .wr_data(in_data),
      .take   (hold_take),
      .full   (hold_full),
      .data   (hold_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         sh_reg      <= '0;
         seq_out_reg <= IDLE_BIT;
`ifdef SEQ_SERIALIZER_PARITY_EN
         par_reg     <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         sh_reg      <= sh_next;
         seq_out_reg <= seq_out_next;
`ifdef SEQ_SERIALIZER_PARITY_EN
         par_reg     <= par_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      sh_next      = sh_reg;
      seq_out_next = seq_out_reg;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par_next     = par_reg;
`endif
      if (load_en) begin
         // MSB goes straight to the output flop; sh_reg keeps the remaining bits left-aligned.
         state_next   = ST_SHIFT;
         cnt_next     = CNT_LOAD;
         seq_out_next = load_word[DATA_W-1];
         sh_next      = {load_word[DATA_W-2:0], 1'b0};
`ifdef SEQ_SERIALIZER_PARITY_EN
         par_next     = ^load_word;
`endif
      end else if (shifter_free) begin
         state_next   = ST_IDLE;
         cnt_next     = '0;
         seq_out_next = IDLE_BIT;
      end else begin
         cnt_next     = cnt_reg - 1'b1;
         seq_out_next = sh_reg[DATA_W-1];
         sh_next      = {sh_reg[DATA_W-2:0], 1'b0};
`ifdef SEQ_SERIALIZER_PARITY_EN
         if (cnt_reg == CNT_W'(1)) begin
            seq_out_next = par_reg;
         end
`endif
      end
   end

   assign in_ready  = !hold_full;
   assign seq_out   = seq_out_reg;
   assign seq_vld   = (state_reg == ST_SHIFT);
   assign word_done = (state_reg == ST_SHIFT) && (cnt_reg == '0);
   assign busy      = (state_reg == ST_SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench: stimulus queues expected serial bits, a negedge monitor pops and compares.
module tb_seq_serializer;
   import seq_pkg::*;

   localparam int   DATA_W   = 8;
   localparam int   FL       = frame_len_f(DATA_W);
   localparam logic IDLE_BIT = 1'b0;

   typedef struct packed {
      logic b;
      logic done;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              seq_out;
   logic              seq_vld;
   logic              word_done;
   logic              busy;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   det_count = 0;
   logic [3:0] det_sh = '0;
   int   run_len = 0;
   int   last_run = 0;
   int   waits = 0;

   seq_serializer #(
      .DATA_W  (DATA_W),
      .IDLE_BIT(IDLE_BIT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .seq_out  (seq_out),
      .seq_vld  (seq_vld),
      .word_done(word_done),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic push_word(input logic [DATA_W-1:0] w);
      for (int i = DATA_W - 1; i >= 0; i--) begin
         exp_q.push_back('{b: w[i], done: (i == 0 && FL == DATA_W)});
      end
      if (FL > DATA_W) begin
         exp_q.push_back('{b: ^w, done: 1'b1});
      end
   endtask

   // Leaves in_valid high on return so consecutive calls stream back-to-back.
   task automatic send(input logic [DATA_W-1:0] w, output int nwait);
      bit accepted;
      nwait = 0;
      accepted = 0;
      in_data = w;
      in_valid = 1'b1;
      while (!accepted && nwait <= 50) begin
         @(negedge clk);
         if (in_ready) accepted = 1;
         else nwait++;
      end
      if (!accepted) begin
         check("send_timeout", 0, 1);
      end else begin
         push_word(w);
      end
      @(posedge clk);
      #1;
      $display("send word=%0h waits=%0d", w, nwait);
   endtask

   task automatic idle_cycles(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && seq_vld) begin
            run_len++;
            det_sh = {det_sh[2:0], seq_out};
            if (det_sh == 4'b1001) det_count++;
            if (exp_q.size() == 0) begin
               check("unexpected_bit", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("seq_out", seq_out, e.b);
               check("word_done", word_done, e.done);
            end
         end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
            check("idle_seq_out", seq_out, IDLE_BIT);
            check("idle_word_done", word_done, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_seq_out", seq_out, IDLE_BIT);
      check("rst_seq_vld", seq_vld, 0);
      check("rst_word_done", word_done, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_busy", busy, 0);

      // Single word 0x90, detector sees 1001 once
      det_count = 0;
      det_sh = '0;
      send(8'h90, waits);
      check("w90_busy", busy, 1);
      idle_cycles(FL + 4);
      check("w90_det_count", det_count, 1);
      check("w90_run", last_run, FL);
      check("w90_busy_end", busy, 0);

      // Back-to-back A5, 3C, FF
      send(8'hA5, waits);
      check("b2b_a_waits", waits, 0);
      send(8'h3C, waits);
      check("b2b_b_waits", waits, 0);
      check("b2b_hold_full_ready", in_ready, 0);
      check("b2b_hold_full_busy", busy, 1);
      send(8'hFF, waits);
      check("b2b_c_waits", waits, FL - 1);
      idle_cycles(3 * FL + 4);
      check("b2b_run", last_run, 3 * FL);
      check("b2b_queue_empty", exp_q.size(), 0);

      // Transfer exactly on the word_done cycle with hold empty
      send(8'hC3, waits);
      in_valid = 1'b0;
      repeat (FL - 1) @(posedge clk);
      #1;
      check("wd_cycle_word_done", word_done, 1);
      check("wd_cycle_in_ready", in_ready, 1);
      send(8'h5A, waits);
      check("bypass_waits", waits, 0);
      check("bypass_hold_empty", in_ready, 1);
      idle_cycles(FL + 4);
      check("bypass_run", last_run, 2 * FL);

      // Reset mid-frame
      send(8'h81, waits);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("async_seq_out", seq_out, IDLE_BIT);
      check("async_seq_vld", seq_vld, 0);
      check("async_word_done", word_done, 0);
      check("async_busy", busy, 0);
      check("async_in_ready", in_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'h09, waits);
      check("after_rst_waits", waits, 0);
      idle_cycles(FL + 4);
      check("after_rst_run", last_run, FL);

      // 0x07 (parity trailer when enabled)
      send(8'h07, waits);
      idle_cycles(FL + 4);
      check("w07_run", last_run, FL);
      check("final_queue_empty", exp_q.size(), 0);
      check("final_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
